fsk2_rx: RTL

//  2FSK non-coherent demodulator; consumes the low-pass-filtered FSK waveform (fir_lowpassfilter output y).

---
 rtl/fsk2_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fsk2_rx.sv
// fsk2_rx: 2FSK non-coherent demodulator. Counts hysteresis-qualified zero crossings per bit window,
//   slices each window to one bit and reassembles an MSB-first word framed by rx_flag.
// Latency: bit_valid 1 clk after a window's last sample; rx_valid 2 clk after the frame's last sample.
// Backpressure: none; one sample is consumed every clock, and dropping rx_flag mid-frame aborts it.
//
// Ports:
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   rx_flag             frame envelope, high for the whole received frame
//   x                   signed filtered sample, one per clock
//   bit_out/bit_valid   last sliced bit and its 1-cycle strobe
//   data_out/rx_valid   received word (held between frames) and its 1-cycle strobe
//   rx_busy             high while a frame is being decoded
//   rx_err              1-cycle strobe when a frame is aborted
module fsk2_rx #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_BITS = 16,
  parameter int BIT_CYC  = 50,
  parameter int HYST     = 16,
  parameter int ZC_TH    = 7
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       rx_flag,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic        [NUM_BITS-1:0] data_out,
  output logic                       rx_valid,
  output logic                       rx_busy,
  output logic                       rx_err
);

  localparam int ZC_W  = $clog2(BIT_CYC + 1);
  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BC_W  = $clog2(NUM_BITS + 1);

  localparam logic        [ZC_W-1:0]     ZC_MAX  = '1;
  localparam logic        [ZC_W-1:0]     ZC_THR  = ZC_W'(ZC_TH);
  localparam logic        [CYC_W-1:0]    CYC_END = CYC_W'(BIT_CYC - 1);
  localparam logic        [BC_W-1:0]     BC_END  = BC_W'(NUM_BITS - 1);
  localparam logic signed [SAMPLE_W-1:0] HYST_P  = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_N  = SAMPLE_W'(-HYST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_sign_pos;
  logic                r_rearm;
  logic [CYC_W-1:0]    r_cyc;
  logic [ZC_W-1:0]     r_zc;
  logic [BC_W-1:0]     r_bit_cnt;
  logic [NUM_BITS-1:0] r_shreg;
  logic [NUM_BITS-1:0] r_data;
  logic                r_bit_out;
  logic                r_bit_vld;
  logic                r_rx_vld;
  logic                r_rx_err;
  logic                r_busy;

  logic            w_above;
  logic            w_below;
  logic            w_cross;
  logic [ZC_W-1:0] w_zc_next;
  logic            w_bit;
  logic            w_last;
  logic            w_start;

  // A crossing is a change of the hysteresis sign state; samples inside the band never flip it.
  assign w_above   = (x > HYST_P);
  assign w_below   = (x < HYST_N);
  assign w_cross   = (w_above && !r_sign_pos) || (w_below && r_sign_pos);
  assign w_zc_next = (r_zc == ZC_MAX) ? r_zc : r_zc + ZC_W'(w_cross);
  // The decision uses the count including the window's final sample.
  assign w_bit     = (w_zc_next >= ZC_THR);
  assign w_last    = (r_cyc == CYC_END);
  // A new frame needs rx_flag to have been low since the previous frame started.
  assign w_start   = rx_flag && r_rearm;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sign_pos <= 1'b1;
    end else if (w_above) begin
      r_sign_pos <= 1'b1;
    end else if (w_below) begin
      r_sign_pos <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_rearm   <= 1'b1;
      r_cyc     <= '0;
      r_zc      <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_bit_out <= 1'b0;
      r_bit_vld <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_rx_err  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_bit_vld <= 1'b0;
      r_rx_vld  <= 1'b0;
      r_rx_err  <= 1'b0;
      if (!rx_flag) begin
        r_rearm <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_state == S_DONE) begin
            r_data   <= r_shreg;
            r_rx_vld <= 1'b1;
          end
          if (w_start) begin
            // The entry-cycle sample is the window's first sample, so it is
            // already counted here and the cycle counter continues from 1.
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_rearm   <= 1'b0;
            r_cyc     <= CYC_W'(1);
            r_zc      <= ZC_W'(w_cross);
            r_bit_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (!rx_flag) begin
            // Abort wins over a decision in the same cycle; the partial bit is dropped.
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_rx_err <= 1'b1;
          end else if (w_last) begin
            r_shreg   <= {r_shreg[NUM_BITS-2:0], w_bit};
            r_bit_out <= w_bit;
            r_bit_vld <= 1'b1;
            r_zc      <= '0;
            r_cyc     <= '0;
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
            if (r_bit_cnt == BC_END) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_zc  <= w_zc_next;
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_vld;
  assign data_out  = r_data;
  assign rx_valid  = r_rx_vld;
  assign rx_busy   = r_busy;
  assign rx_err    = r_rx_err;

endmodule
